// File: rtl/alarm_ctrl_fsm.sv
// Alarm clock key-entry / mode controller: sequences keypad digits and
// decides whether a 4-digit entry loads the alarm register or the current time.
//
// state            | meaning
// SHOW_TIME        | idle, display shows current time
// KEY_STORED       | shift the pressed digit into the key register
// KEY_WAITED       | wait for the key to be released
// KEY_ENTRY        | between digits, waiting for a key or a button
// SHOW_ALARM       | display shows the alarm time while alarm_button held
// SET_ALARM_TIME   | one-cycle load of the alarm register
// SET_CURRENT_TIME | one-cycle load of the time counter and divider clear
module alarm_ctrl_fsm #(
  parameter int         TIMEOUT = 10,
  parameter logic [3:0] NOKEY   = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       reset_count,
  output logic       show_new_time,
  output logic       show_a
);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] digits_q, digits_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic       key_idle, full, timeout, wait_q, wait_d;

  assign key_idle = (key == NOKEY);
  assign full     = (digits_q == 3'd4);
  // >= also covers a pulse swallowed by a key release on the last count
  assign timeout  = one_second && (tcnt_q >= TO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= SHOW_TIME;
      digits_q <= 3'd0;
      tcnt_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW_TIME: begin
        if (alarm_button)   state_d = SHOW_ALARM;
        else if (!key_idle) state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (key_idle)     state_d = KEY_ENTRY;
        else if (timeout) state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)     state_d = full ? SET_ALARM_TIME : SHOW_TIME;
        else if (time_button) state_d = full ? SET_CURRENT_TIME : SHOW_TIME;
        else if (!key_idle)   state_d = KEY_STORED;
        else if (timeout)     state_d = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_d = SHOW_TIME;
      end
      default: state_d = SHOW_TIME;
    endcase
  end

  always_comb begin
    wait_q = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
    wait_d = (state_d == KEY_WAITED) || (state_d == KEY_ENTRY);

    digits_d = digits_q;
    if (state_d == SHOW_TIME)
      digits_d = 3'd0;
    else if ((state_q == KEY_STORED) && !full)
      digits_d = digits_q + 3'd1;

    // counts only while staying in the wait states; any other path clears it
    tcnt_d = (wait_q && wait_d) ? tcnt_q + {3'd0, one_second} : 4'd0;
  end

  always_comb begin
    shift         = (state_q == KEY_STORED);
    load_new_a    = (state_q == SET_ALARM_TIME);
    load_new_c    = (state_q == SET_CURRENT_TIME);
    reset_count   = (state_q == SET_CURRENT_TIME);
    show_new_time = (state_q == KEY_STORED) || (state_q == KEY_WAITED) ||
                    (state_q == KEY_ENTRY);
    show_a        = (state_q == SHOW_ALARM);
  end

endmodule
